// File: rtl/divider_8b4b_seq_if.sv
// rtl/divider_8b4b_seq_if.sv - operand/result handshake bundle for the 8b/4b sequential divider
interface divider_8b4b_seq_if;
  // Operand side: the producer drives these and the divider answers with in_ready.
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;

  // Result side: the divider drives these and the consumer answers with out_ready.
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       dz;

  // Producer/consumer view (testbench or upstream logic).
  modport master (
    output in_valid,
    output dividend,
    output divisor,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
    input  remainder,
    input  dz
  );

  // Divider view.
  modport slave (
    input  in_valid,
    input  dividend,
    input  divisor,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
    output remainder,
    output dz
  );
endinterface

// File: rtl/divider_8b4b_seq.sv
// rtl/divider_8b4b_seq.sv - 8b/4b unsigned restoring divider, one quotient bit per clock (option macro: DIV_BY_ZERO_EN)
module divider_8b4b_seq (
  input  logic              clk,
  input  logic              rst_n,
  divider_8b4b_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;

  // Working registers: dividend shifter, captured divisor, partial remainder,
  // quotient accumulator and iteration counter.
  logic [7:0] d_q, d_d;
  logic [3:0] v_q, v_d;
  logic [3:0] r_q, r_d;
  logic [7:0] q_q, q_d;
  logic [2:0] cnt_q, cnt_d;

  // Registered outputs.
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] quotient_q, quotient_d;
  logic [3:0] remainder_q, remainder_d;
  logic       dz_q, dz_d;

  // One restoring step.
  logic [4:0] r5;
  logic       step_ge;
  logic [3:0] step_r;
  logic [7:0] step_q;

  // Zero-divisor short-circuit request.
  logic       zero_skip;

  // Restoring step: bring in the next dividend bit and subtract the divisor when it fits.
  // R < V before every step keeps R5 <= 30, so when it fits the difference is below 16
  // and a 4-bit subtract on the low bits is exact.
  always_comb begin
    r5      = {r_q, d_q[7]};
    step_ge = (r5 >= {1'b0, v_q});
    step_r  = step_ge ? (r5[3:0] - v_q) : r5[3:0];
    step_q  = {q_q[6:0], step_ge};
  end

  // Decide whether a zero divisor bypasses the iterations.
`ifdef DIV_BY_ZERO_EN
  always_comb begin
    zero_skip = (v_q == 4'd0);
  end
`else
  always_comb begin
    zero_skip = 1'b0;
  end
`endif

  // Next-state and next-output computation for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    v_d         = v_q;
    r_d         = r_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          state_d    = BUSY;
          d_d        = bus.dividend;
          v_d        = bus.divisor;
          r_d        = 4'd0;
          q_d        = 8'd0;
          cnt_d      = 3'd0;
          in_ready_d = 1'b0;
        end else begin
          in_ready_d = 1'b1;
        end
      end

      BUSY: begin
        if (zero_skip) begin
          // Dividing by zero subtracts nothing at every step: all-ones quotient
          // and the low dividend nibble as remainder, produced in one cycle.
          state_d     = DONE;
          out_valid_d = 1'b1;
          quotient_d  = 8'hFF;
          remainder_d = d_q[3:0];
          dz_d        = 1'b1;
        end else begin
          d_d   = {d_q[6:0], 1'b0};
          r_d   = step_r;
          q_d   = step_q;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            quotient_d  = step_q;
            remainder_d = step_r;
          end
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          dz_d        = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b0;
        dz_d        = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous active-low reset aborts any operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      d_q         <= 8'd0;
      v_q         <= 4'd0;
      r_q         <= 4'd0;
      q_q         <= 8'd0;
      cnt_q       <= 3'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= 8'd0;
      remainder_q <= 4'd0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      v_q         <= v_d;
      r_q         <= r_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_q        <= dz_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.dz        = dz_q;

endmodule

// File: tb/tb_divider_8b4b_seq.sv
// tb/tb_divider_8b4b_seq.sv - scoreboard bench for divider_8b4b_seq (honours DIV_BY_ZERO_EN)
module tb_divider_8b4b_seq;

  typedef struct {
    int q;
    int r;
    int dz;
    int a;
    int b;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  divider_8b4b_seq_if bus ();

  divider_8b4b_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Wait for in_ready, present operands for one accept edge, optionally queue the expectation.
  task automatic send(input int a, input int b, input int eq, input int er, input int ed,
                      input bit push, output int acc_cyc);
    int w;
    exp_t e;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("in_ready_before_accept", bus.in_ready, 1);
    bus.dividend = a[7:0];
    bus.divisor  = b[3:0];
    bus.in_valid = 1'b1;
    if (push) begin
      e.q = eq; e.r = er; e.dz = ed; e.a = a; e.b = b;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
  endtask

  // Count edges from accept until out_valid; optionally wiggle the operand inputs meanwhile.
  task automatic wait_result(input bit pulse, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      if (pulse) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.dividend = 8'($urandom_range(0, 255));
        bus.divisor  = 4'($urandom_range(0, 15));
      end
      @(posedge clk);
      #1;
      lat++;
    end
    bus.in_valid = 1'b0;
  endtask

  // Monitor: every completed result transfer is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", int'(bus.quotient), mon_e.q);
        check("remainder", int'(bus.remainder), mon_e.r);
        check("dz", int'(bus.dz), mon_e.dz);
        if (mon_e.b != 0) begin
          check("q_times_v_plus_r", int'(bus.quotient) * mon_e.b + int'(bus.remainder), mon_e.a);
          check("rem_below_div", int'(bus.remainder < 4'(mon_e.b)), 1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, prev_acc, lat, a, b;
    int dz_exp, dz_lat;
    int vec[4][4];

    vec[0] = '{200, 7, 28, 4};
    vec[1] = '{255, 1, 255, 0};
    vec[2] = '{5, 9, 0, 5};
    vec[3] = '{255, 15, 17, 0};

`ifdef DIV_BY_ZERO_EN
    dz_exp = 1;
    dz_lat = 1;
`else
    dz_exp = 0;
    dz_lat = 8;
`endif

    bus.in_valid  = 1'b0;
    bus.dividend  = 8'd0;
    bus.divisor   = 4'd0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_quotient", int'(bus.quotient), 0);
    check("rst_remainder", int'(bus.remainder), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_dz", int'(bus.dz), 0);
    check("rst_in_ready_low", int'(bus.in_ready), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_release", int'(bus.in_ready), 1);

    // Directed corner vectors, back to back with out_ready high
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      send(vec[i][0], vec[i][1], vec[i][2], vec[i][3], 0, 1'b1, acc);
      if (i > 0) check("accept_spacing", acc - prev_acc, 10);
      prev_acc = acc;
      wait_result(1'b0, lat);
      check("latency", lat, 8);
      if (i == 0) begin
        @(posedge clk);
        #1;
        check("out_valid_one_cycle", int'(bus.out_valid), 0);
        check("in_ready_after_transfer", int'(bus.in_ready), 1);
      end
    end

    // Zero divisor 0xA7/0
    send(8'hA7, 0, 8'hFF, 7, dz_exp, 1'b1, acc);
    wait_result(1'b0, lat);
    check("dz_latency", lat, dz_lat);
    check("dz_flag_while_valid", int'(bus.dz), dz_exp);
    @(posedge clk);
    #1;
    check("dz_cleared_after_transfer", int'(bus.dz), 0);
    check("out_valid_cleared_after_dz", int'(bus.out_valid), 0);

    // Backpressure 100/3
    bus.out_ready = 1'b0;
    send(100, 3, 33, 1, 0, 1'b1, acc);
    wait_result(1'b0, lat);
    check("bp_latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid_held", int'(bus.out_valid), 1);
      check("bp_quotient_held", int'(bus.quotient), 33);
      check("bp_remainder_held", int'(bus.remainder), 1);
      check("bp_in_ready_low", int'(bus.in_ready), 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_transfer_done", int'(bus.out_valid), 0);
    check("bp_in_ready_back", int'(bus.in_ready), 1);

    // Reset on the 4th BUSY cycle aborts the operation
    send(200, 7, 0, 0, 0, 1'b0, acc);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_quotient", int'(bus.quotient), 0);
    check("midrst_remainder", int'(bus.remainder), 0);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_in_ready", int'(bus.in_ready), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready_release", int'(bus.in_ready), 1);
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_result", int'(bus.out_valid), 0);
    send(50, 6, 8, 2, 0, 1'b1, acc);
    wait_result(1'b0, lat);
    check("post_rst_latency", lat, 8);

    // Back-to-back random operands with in_valid noise during BUSY
    prev_acc = 0;
    for (int i = 0; i < 20; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(1, 15);
      send(a, b, a / b, a % b, 0, 1'b1, acc);
      if (i > 0) check("rand_accept_spacing", acc - prev_acc, 10);
      prev_acc = acc;
      wait_result(1'b1, lat);
      check("rand_latency", lat, 8);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
